llc_snoop_responder: RTL and testbench
======================================

# llc_snoop_responder

- Synthesizable snoop-side stage of the last-level cache.
- Accepts one foreign bus transaction at a time and looks the address up in the LLC tag/state array.
- Drives the L2→L1 messages and the modified-line writeback, then returns the snoop result (NOHIT/HIT/HITM) and the new MESI state.
- Sits between the bus-operation front end and the LLC tag array; the bus front end reports its `snoop_result` output.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `ID_W`, 4, cache-id width
- `MY_ID`, 0, this cache's id; transactions carrying it are self-snoops
- `LK_TIMEOUT`, 15, max cycles waiting for `lk_ack` (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- Bus transaction in:
  - `bus_valid` in 1, `bus_ready` out 1: handshake.
  - `bus_op` in 3: READ=1, WRITE=2, INVALIDATE=3, RWIM=4.
  - `bus_addr` in ADDR_W, `bus_id` in ID_W.
- Tag lookup:
  - `lk_req` out 1, `lk_addr` out ADDR_W.
  - `lk_ack` in 1, `lk_hit` in 1.
  - `lk_mesi` in 2: I=0, S=1, E=2, M=3.
- State update: `upd_valid` out 1 (pulse), `upd_addr` out ADDR_W, `upd_mesi` out 2.
- L1 message:
  - `l1_valid` out 1, `l1_ready` in 1.
  - `l1_msg` out 3: GETLINE=1, INVALIDATELINE=3.
  - `l1_addr` out ADDR_W.
- Writeback: `wb_valid` out 1, `wb_ready` in 1, `wb_addr` out ADDR_W.
- Response:
  - `snoop_valid` out 1 (pulse).
  - `snoop_result` out 2: NOHIT=0, HIT=1, HITM=2.
  - `snoop_addr` out ADDR_W.
- Status:
  - `lk_err` out 1: sticky lookup-timeout flag.
  - `hit_cnt` out 16, `hitm_cnt` out 16.

## Operation
- FSM states: IDLE, LOOKUP, GETL1, WB, INVL1, RESP.
- `bus_ready` = 1 only in IDLE. The transaction is captured on `bus_valid && bus_ready`; address and op are held internally.
- Self-snoop (`bus_id==MY_ID`): captured, no lookup, no outputs, stay IDLE.
- WRITE: no lookup → RESP with NOHIT, no update.
- READ, INVALIDATE, RWIM → LOOKUP; `lk_req`=1 with `lk_addr` held until the `lk_ack` cycle, where `lk_hit`/`lk_mesi` are sampled. Miss, or `lk_mesi==I`, is treated as I.
- Action by op and sampled state (→ new state; result):
  - READ
    - I: no change; NOHIT.
    - S: stays S; HIT.
    - E: → S; HIT.
    - M: GETL1(GETLINE) → WB → S; HITM.
  - RWIM
    - I: NOHIT.
    - S/E: INVL1 → I; HIT.
    - M: GETL1 → WB → INVL1 → I; HITM.
  - INVALIDATE
    - S: INVL1 → I; HIT.
    - I/E/M: no change; NOHIT (E/M cannot legally see INVALIDATE; no action).
- GETL1, INVL1 and WB each hold `*_valid` and address stable until their ready; advance on the handshake cycle.
- RESP (one cycle):
  - `snoop_valid`=1 with result and address.
  - `upd_valid`=1 only if state changes.
  - Then → IDLE.
- Lookup timeout: if `lk_ack` is not seen within `LK_TIMEOUT` cycles of LOOKUP, the lookup is treated as a miss (NOHIT), `lk_err` is set, and `lk_req` drops.

## Timing
- Reset: every output 0 except `bus_ready`=1; FSM to IDLE; `lk_err` and counters clear. An in-flight transaction is dropped with no response.
- Latency:
  - WRITE: capture cycle 0, RESP cycle 1, `bus_ready` cycle 2.
  - Lookup with same-cycle ack: `lk_req` cycle 1, RESP cycle 2, `bus_ready` cycle 3.
  - Each L1/WB handshake adds ≥1 cycle.
- `lk_ack` arriving outside LOOKUP is ignored.
- `lk_ack` in the same cycle as timeout expiry: the ack wins and `lk_err` is not set.
- Back-to-back: a new capture is possible the cycle after RESP.

## Configuration
- `SNOOP_STATS_EN` defined:
  - `hit_cnt` increments on every RESP with HIT.
  - `hitm_cnt` increments on every RESP with HITM.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared by reset.
- Undefined: counter logic absent; `hit_cnt`/`hitm_cnt` tied to 0.

## Test plan
- READ 0x0000_1040 from id 2, `lk_mesi`=E, ack cycle 1 → `snoop_valid` cycle 2, HIT; `upd_mesi`=S; no `l1_valid`/`wb_valid`.
- RWIM 0x0000_2000, `lk_mesi`=M, `l1_ready`/`wb_ready` delayed 3 cycles each:
  - Messages in order GETLINE → writeback → INVALIDATELINE.
  - Response HITM, `upd_mesi`=I.
  - `hitm_cnt`=1 with `SNOOP_STATS_EN`, 0 without.
- WRITE 0x0000_3000 from id 5 → no `lk_req`, NOHIT on cycle 1; READ with `bus_id==MY_ID` → no outputs, `bus_ready` stays high.
- READ with `lk_ack` never asserted, `LK_TIMEOUT`=15 → `lk_req` drops after 15 cycles, NOHIT, `lk_err`=1 until reset.
- `rst_n` asserted during WB with `wb_valid`=1 → all outputs 0 immediately; after release `bus_ready`=1 and no `snoop_valid` for the dropped transaction.

Source files
------------

// File: rtl/llc_snoop_responder.sv
`default_nettype none
// llc_snoop_responder: LLC snoop stage (tag lookup, L1 recall/invalidate, writeback, snoop response). Rev 1.0
// Define SNOOP_STATS_EN to build the saturating hit_cnt/hitm_cnt counters; otherwise they read 0.
module llc_snoop_responder #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int MY_ID      = 0,
  parameter int LK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [2:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [ID_W-1:0]   bus_id,
  output logic              lk_req,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_ack,
  input  logic              lk_hit,
  input  logic [1:0]        lk_mesi,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [1:0]        upd_mesi,
  output logic              l1_valid,
  input  logic              l1_ready,
  output logic [2:0]        l1_msg,
  output logic [ADDR_W-1:0] l1_addr,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              snoop_valid,
  output logic [1:0]        snoop_result,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic              lk_err,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       hitm_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_GETL1 = 3'd2,
                         S_WB   = 3'd3, S_INVL1  = 3'd4, S_RESP  = 3'd5;
  localparam logic [2:0] OP_READ = 3'd1, OP_INV = 3'd3, OP_RWIM = 3'd4;
  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [1:0] RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2;
  localparam logic [2:0] MSG_GETLINE = 3'd1, MSG_INVLINE = 3'd3;
  localparam int         TW = $clog2(LK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LK_TIMEOUT - 1);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_op;
  logic [1:0]        r_result, r_new_mesi;
  logic              r_upd, r_inv, r_lk_err;
  logic [TW-1:0]     r_timer;

  logic              w_capture, w_self, w_needs_lk, w_timeout;
  logic [1:0]        w_eff, w_res, w_nm;
  logic              w_upd, w_get, w_inv;

  assign w_capture  = (state == S_IDLE) && bus_valid;
  assign w_self     = (bus_id == ID_W'(MY_ID));
  assign w_needs_lk = (bus_op == OP_READ) || (bus_op == OP_INV) || (bus_op == OP_RWIM);
  assign w_timeout  = (r_timer == TMO_LAST) && !lk_ack;
  assign lk_err     = r_lk_err;

  // Snoop action for the captured op against the state returned by the tag array.
  always_comb begin
    w_eff = lk_hit ? lk_mesi : MESI_I;
    w_res = RES_NOHIT;
    w_upd = 1'b0;
    w_nm  = MESI_I;
    w_get = 1'b0;
    w_inv = 1'b0;
    case (r_op)
      OP_READ: begin
        w_get = (w_eff == MESI_M);
        w_upd = (w_eff == MESI_E) || (w_eff == MESI_M);
        w_nm  = MESI_S;
        if (w_eff == MESI_M)      w_res = RES_HITM;
        else if (w_eff != MESI_I) w_res = RES_HIT;
      end
      OP_RWIM: begin
        w_get = (w_eff == MESI_M);
        w_inv = (w_eff != MESI_I);
        w_upd = (w_eff != MESI_I);
        if (w_eff == MESI_M)      w_res = RES_HITM;
        else if (w_eff != MESI_I) w_res = RES_HIT;
      end
      OP_INV: begin
        if (w_eff == MESI_S) begin
          w_inv = 1'b1;
          w_upd = 1'b1;
          w_res = RES_HIT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus_valid && !w_self) state_nxt = w_needs_lk ? S_LOOKUP : S_RESP;
      S_LOOKUP: begin
        if (lk_ack)         state_nxt = w_get ? S_GETL1 : (w_inv ? S_INVL1 : S_RESP);
        else if (w_timeout) state_nxt = S_RESP;
      end
      S_GETL1:  if (l1_ready) state_nxt = S_WB;
      S_WB:     if (wb_ready) state_nxt = r_inv ? S_INVL1 : S_RESP;
      S_INVL1:  if (l1_ready) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_ready    = 1'b0;
    lk_req       = 1'b0;
    lk_addr      = '0;
    upd_valid    = 1'b0;
    upd_addr     = '0;
    upd_mesi     = MESI_I;
    l1_valid     = 1'b0;
    l1_msg       = 3'd0;
    l1_addr      = '0;
    wb_valid     = 1'b0;
    wb_addr      = '0;
    snoop_valid  = 1'b0;
    snoop_result = RES_NOHIT;
    snoop_addr   = '0;
    case (state)
      S_IDLE:   bus_ready = 1'b1;
      S_LOOKUP: begin lk_req = 1'b1; lk_addr = r_addr; end
      S_GETL1:  begin l1_valid = 1'b1; l1_msg = MSG_GETLINE; l1_addr = r_addr; end
      S_WB:     begin wb_valid = 1'b1; wb_addr = r_addr; end
      S_INVL1:  begin l1_valid = 1'b1; l1_msg = MSG_INVLINE; l1_addr = r_addr; end
      S_RESP: begin
        snoop_valid  = 1'b1;
        snoop_result = r_result;
        snoop_addr   = r_addr;
        upd_valid    = r_upd;
        upd_addr     = r_upd ? r_addr : '0;
        upd_mesi     = r_upd ? r_new_mesi : MESI_I;
      end
      default: ;
    endcase
  end

  // Transaction context; result defaults to NOHIT so WRITE and timeout need no extra path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_op       <= 3'd0;
      r_result   <= RES_NOHIT;
      r_new_mesi <= MESI_I;
      r_upd      <= 1'b0;
      r_inv      <= 1'b0;
      r_timer    <= '0;
      r_lk_err   <= 1'b0;
    end else if (w_capture) begin
      r_addr     <= bus_addr;
      r_op       <= bus_op;
      r_result   <= RES_NOHIT;
      r_new_mesi <= MESI_I;
      r_upd      <= 1'b0;
      r_inv      <= 1'b0;
      r_timer    <= '0;
    end else if (state == S_LOOKUP) begin
      r_timer <= r_timer + TW'(1);
      if (lk_ack) begin
        r_result   <= w_res;
        r_new_mesi <= w_nm;
        r_upd      <= w_upd;
        r_inv      <= w_inv;
      end else if (w_timeout) begin
        r_lk_err <= 1'b1;
      end
    end
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      hitm_cnt <= '0;
    end else if (state == S_RESP) begin
      if (r_result == RES_HIT && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
      if (r_result == RES_HITM && hitm_cnt != 16'hFFFF) hitm_cnt <= hitm_cnt + 16'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign hitm_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_llc_snoop_responder.sv
`default_nettype none
// tb_llc_snoop_responder: randomized snoop transactions checked against a rule-level MESI snoop model.
module tb_llc_snoop_responder;
  localparam int ADDR_W = 32, ID_W = 4, MY_ID = 0, LK_TIMEOUT = 15;
`ifdef SNOOP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic bus_valid = 1'b0, bus_ready;
  logic [2:0] bus_op = '0;
  logic [ADDR_W-1:0] bus_addr = '0;
  logic [ID_W-1:0] bus_id = '0;
  logic lk_req, lk_ack = 1'b0, lk_hit = 1'b0;
  logic [ADDR_W-1:0] lk_addr, upd_addr, l1_addr, wb_addr, snoop_addr;
  logic [1:0] lk_mesi = '0, upd_mesi, snoop_result;
  logic upd_valid, l1_valid, l1_ready = 1'b0, wb_valid, wb_ready = 1'b0, snoop_valid, lk_err;
  logic [2:0] l1_msg;
  logic [15:0] hit_cnt, hitm_cnt;
  logic busy_outs;

  llc_snoop_responder #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MY_ID(MY_ID), .LK_TIMEOUT(LK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_id(bus_id), .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack),
    .lk_hit(lk_hit), .lk_mesi(lk_mesi), .upd_valid(upd_valid), .upd_addr(upd_addr),
    .upd_mesi(upd_mesi), .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_msg(l1_msg),
    .l1_addr(l1_addr), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result), .snoop_addr(snoop_addr),
    .lk_err(lk_err), .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt));

  always #5 clk = ~clk;

  assign busy_outs = lk_req | (|lk_addr) | upd_valid | (|upd_addr) | (|upd_mesi) | l1_valid |
                     (|l1_msg) | (|l1_addr) | wb_valid | (|wb_addr) | snoop_valid |
                     (|snoop_result) | (|snoop_addr);

  int checks = 0, failures = 0;
  // Observations from the last transaction
  int o_snoop_cyc, o_lk_first, o_lk_cycles, o_sig, o_addr_err;
  bit o_any_out, o_ready_low, o_ready_after, o_upd;
  logic [1:0] o_res, o_upd_mesi;
  // Reference model state
  bit m_lk_err = 1'b0;
  int m_hit = 0, m_hitm = 0;

  // Snoop rules: result/update/new state and which L1/WB actions are required.
  function automatic void model(input logic [2:0] op, input bit hit, input logic [1:0] mesi,
                                input bit tmo, output logic [1:0] res, output bit upd,
                                output logic [1:0] nm, output bit get, output bit inv);
    logic [1:0] eff;
    eff = (hit && !tmo) ? mesi : 2'd0;
    res = 2'd0; upd = 0; nm = 2'd0; get = 0; inv = 0;
    if (op == 3'd1 || op == 3'd4) begin
      res = (eff == 2'd3) ? 2'd2 : (eff == 2'd0) ? 2'd0 : 2'd1;
      get = (eff == 2'd3);
      if (op == 3'd1) begin upd = (eff >= 2'd2); nm = 2'd1; end
      else begin upd = (eff != 2'd0); inv = upd; end
    end else if (op == 3'd3 && eff == 2'd1) begin
      res = 2'd1; upd = 1; inv = 1;
    end
  endfunction

  // Drives one transaction from the current cycle (0) and acts as the lookup/L1/WB responders.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] id,
                         input bit hit, input logic [1:0] mesi, input int ack_dly,
                         input int l1_dly, input int wb_dly, input int budget);
    int l1_w = 0, wb_w = 0;
    o_snoop_cyc = -1; o_lk_first = -1; o_lk_cycles = 0; o_sig = 0; o_addr_err = 0;
    o_any_out = 0; o_ready_low = 0; o_ready_after = 0; o_upd = 0; o_res = 2'd3; o_upd_mesi = 2'd0;
    bus_valid = 1'b1; bus_op = op; bus_addr = addr; bus_id = id; lk_ack = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      bus_valid = 1'b0; bus_op = 3'($urandom); bus_addr = $urandom;
      lk_ack = 1'($urandom); lk_hit = 1'($urandom); lk_mesi = 2'($urandom);
      l1_ready = 1'b0; wb_ready = 1'b0;
      if (!bus_ready) o_ready_low = 1;
      if (lk_req | l1_valid | wb_valid | snoop_valid | upd_valid) o_any_out = 1;
      if (lk_req) begin
        lk_ack = 1'b0;
        if (o_lk_first < 0) o_lk_first = c;
        if (lk_addr !== addr) o_addr_err++;
        if (o_lk_cycles == ack_dly) begin lk_ack = 1'b1; lk_hit = hit; lk_mesi = mesi; end
        o_lk_cycles++;
      end
      if (l1_valid) begin
        if (l1_addr !== addr) o_addr_err++;
        if (l1_w == l1_dly) begin l1_ready = 1'b1; o_sig = (o_sig << 2) | int'(l1_msg); l1_w = 0; end
        else l1_w++;
      end
      if (wb_valid) begin
        if (wb_addr !== addr) o_addr_err++;
        if (wb_w == wb_dly) begin wb_ready = 1'b1; o_sig = (o_sig << 2) | 2; wb_w = 0; end
        else wb_w++;
      end
      if (snoop_valid) begin
        o_snoop_cyc = c; o_res = snoop_result; o_upd = upd_valid;
        o_upd_mesi = upd_valid ? upd_mesi : 2'd0;
        if (snoop_addr !== addr || (upd_valid && upd_addr !== addr)) o_addr_err++;
        @(posedge clk); #1;
        lk_ack = 1'b0;
        o_ready_after = bus_ready;
        break;
      end
    end
    lk_ack = 1'b0; l1_ready = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus_ready !== 1'b1) begin failures++; $display("FAIL reset bus_ready: got %b exp 1", bus_ready); end
    checks++; if (busy_outs !== 1'b0) begin failures++; $display("FAIL reset outputs: got nonzero exp 0"); end
    checks++; if ({lk_err, hit_cnt, hitm_cnt} !== 33'd0) begin failures++; $display("FAIL reset status: got %b/%0d/%0d exp 0", lk_err, hit_cnt, hitm_cnt); end
  endtask

  task automatic test_read_e();
    run_txn(3'd1, 32'h0000_1040, 4'd2, 1'b1, 2'd2, 0, 0, 0, 40);
    m_hit++;
    checks++; if (o_lk_first !== 1) begin failures++; $display("FAIL read_e lk_req cycle: got %0d exp 1", o_lk_first); end
    checks++; if (o_snoop_cyc !== 2) begin failures++; $display("FAIL read_e snoop cycle: got %0d exp 2", o_snoop_cyc); end
    checks++; if (o_res !== 2'd1) begin failures++; $display("FAIL read_e result: got %0d exp 1", o_res); end
    checks++; if ({o_upd, o_upd_mesi} !== 3'b101) begin failures++; $display("FAIL read_e update: got %b/%0d exp 1/1", o_upd, o_upd_mesi); end
    checks++; if (o_sig !== 0) begin failures++; $display("FAIL read_e l1/wb traffic: got %0d exp 0", o_sig); end
    checks++; if (o_ready_after !== 1'b1) begin failures++; $display("FAIL read_e ready after: got %b exp 1", o_ready_after); end
  endtask

  task automatic test_rwim_m();
    run_txn(3'd4, 32'h0000_2000, 4'd7, 1'b1, 2'd3, 0, 3, 3, 60);
    m_hitm++;
    checks++; if (o_sig !== 27) begin failures++; $display("FAIL rwim_m sequence: got %0d exp 27", o_sig); end
    checks++; if (o_res !== 2'd2) begin failures++; $display("FAIL rwim_m result: got %0d exp 2", o_res); end
    checks++; if ({o_upd, o_upd_mesi} !== 3'b100) begin failures++; $display("FAIL rwim_m update: got %b/%0d exp 1/0", o_upd, o_upd_mesi); end
    checks++; if (o_snoop_cyc !== 14) begin failures++; $display("FAIL rwim_m snoop cycle: got %0d exp 14", o_snoop_cyc); end
    checks++; if (hitm_cnt !== (STATS ? 16'd1 : 16'd0)) begin failures++; $display("FAIL rwim_m hitm_cnt: got %0d exp %0d", hitm_cnt, STATS); end
    checks++; if (o_addr_err !== 0) begin failures++; $display("FAIL rwim_m addresses: got %0d errors exp 0", o_addr_err); end
  endtask

  task automatic test_write_self();
    run_txn(3'd2, 32'h0000_3000, 4'd5, 1'b1, 2'd3, 0, 0, 0, 20);
    checks++; if (o_lk_first !== -1) begin failures++; $display("FAIL write lk_req: got cycle %0d exp none", o_lk_first); end
    checks++; if (o_snoop_cyc !== 1 || o_res !== 2'd0 || o_upd !== 1'b0) begin failures++; $display("FAIL write response: got cyc %0d res %0d upd %b exp 1/0/0", o_snoop_cyc, o_res, o_upd); end
    run_txn(3'd1, 32'h0000_4000, 4'(MY_ID), 1'b1, 2'd3, 0, 0, 0, 6);
    checks++; if (o_any_out !== 1'b0 || o_snoop_cyc !== -1) begin failures++; $display("FAIL self_snoop outputs: got active %b snoop cyc %0d exp none", o_any_out, o_snoop_cyc); end
    checks++; if (o_ready_low !== 1'b0 || bus_ready !== 1'b1) begin failures++; $display("FAIL self_snoop bus_ready: got low %b exp stays 1", o_ready_low); end
  endtask

  task automatic test_timeout();
    run_txn(3'd1, 32'h0000_5000, 4'd1, 1'b1, 2'd1, LK_TIMEOUT - 1, 0, 0, 40);
    m_hit++;
    checks++; if (o_res !== 2'd1 || lk_err !== 1'b0) begin failures++; $display("FAIL ack_at_expiry: got res %0d lk_err %b exp 1/0", o_res, lk_err); end
    run_txn(3'd1, 32'h0000_6000, 4'd1, 1'b1, 2'd3, 1000, 0, 0, 40);
    m_lk_err = 1'b1;
    checks++; if (o_lk_cycles !== LK_TIMEOUT) begin failures++; $display("FAIL timeout lk_req cycles: got %0d exp %0d", o_lk_cycles, LK_TIMEOUT); end
    checks++; if (o_res !== 2'd0 || o_upd !== 1'b0 || o_snoop_cyc !== LK_TIMEOUT + 1) begin failures++; $display("FAIL timeout response: got res %0d upd %b cyc %0d exp 0/0/%0d", o_res, o_upd, o_snoop_cyc, LK_TIMEOUT + 1); end
    checks++; if (lk_err !== 1'b1) begin failures++; $display("FAIL timeout lk_err: got %b exp 1", lk_err); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0] op; logic [1:0] mesi, res, nm; bit hit, upd, get, inv, lookup, tmo;
      int ack_dly, l1_dly, wb_dly, exp_lkc, exp_cyc, exp_sig;
      logic [31:0] addr;
      op = 3'($urandom_range(1, 4)); mesi = 2'($urandom); hit = 1'($urandom); addr = $urandom;
      ack_dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
      l1_dly = int'($urandom_range(0, 3)); wb_dly = int'($urandom_range(0, 3));
      lookup = (op != 3'd2);
      tmo = lookup && (ack_dly >= LK_TIMEOUT);
      model(op, hit, mesi, tmo, res, upd, nm, get, inv);
      exp_lkc = !lookup ? 0 : (tmo ? LK_TIMEOUT : ack_dly + 1);
      exp_cyc = 1 + exp_lkc + (get ? l1_dly + wb_dly + 2 : 0) + (inv ? l1_dly + 1 : 0);
      exp_sig = get ? 6 : 0;
      if (inv) exp_sig = (exp_sig << 2) | 3;
      if (tmo) m_lk_err = 1'b1;
      if (res == 2'd1 && m_hit < 65535) m_hit++;
      if (res == 2'd2 && m_hitm < 65535) m_hitm++;
      run_txn(op, addr, 4'($urandom_range(1, 15)), hit, mesi, ack_dly, l1_dly, wb_dly, 120);
      checks++; if (o_snoop_cyc !== exp_cyc) begin failures++; $display("FAIL rnd%0d snoop cycle: got %0d exp %0d (op %0d)", i, o_snoop_cyc, exp_cyc, op); end
      checks++; if (o_res !== res) begin failures++; $display("FAIL rnd%0d result: got %0d exp %0d (op %0d hit %b mesi %0d)", i, o_res, res, op, hit, mesi); end
      checks++; if ({o_upd, o_upd_mesi} !== {upd, upd ? nm : 2'd0}) begin failures++; $display("FAIL rnd%0d update: got %b/%0d exp %b/%0d", i, o_upd, o_upd_mesi, upd, nm); end
      checks++; if (o_sig !== exp_sig) begin failures++; $display("FAIL rnd%0d l1/wb sequence: got %0d exp %0d", i, o_sig, exp_sig); end
      checks++; if (o_lk_cycles !== exp_lkc || o_addr_err !== 0) begin failures++; $display("FAIL rnd%0d lookup: got %0d cycles %0d addr errs exp %0d/0", i, o_lk_cycles, o_addr_err, exp_lkc); end
      checks++; if (lk_err !== m_lk_err || o_ready_after !== 1'b1) begin failures++; $display("FAIL rnd%0d status: got lk_err %b ready %b exp %b/1", i, lk_err, o_ready_after, m_lk_err); end
      checks++; if (hit_cnt !== (STATS ? 16'(m_hit) : 16'd0) || hitm_cnt !== (STATS ? 16'(m_hitm) : 16'd0)) begin failures++; $display("FAIL rnd%0d counters: got %0d/%0d exp %0d/%0d", i, hit_cnt, hitm_cnt, STATS ? m_hit : 0, STATS ? m_hitm : 0); end
    end
  endtask

  task automatic test_reset_wb();
    bit seen_wb = 0;
    int stray = 0;
    bus_valid = 1'b1; bus_op = 3'd4; bus_addr = 32'h0000_2040; bus_id = 4'd3;
    @(posedge clk); #1;
    bus_valid = 1'b0; lk_ack = 1'b1; lk_hit = 1'b1; lk_mesi = 2'd3; l1_ready = 1'b1; wb_ready = 1'b0;
    for (int c = 0; c < 10 && !seen_wb; c++) begin
      @(posedge clk); #1;
      lk_ack = 1'b0;
      if (wb_valid) seen_wb = 1;
    end
    l1_ready = 1'b0;
    checks++; if (seen_wb !== 1'b1) begin failures++; $display("FAIL reset_wb reach WB: got %b exp 1", seen_wb); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_outs !== 1'b0 || bus_ready !== 1'b1) begin failures++; $display("FAIL reset_wb outputs: got busy %b ready %b exp 0/1", busy_outs, bus_ready); end
    checks++; if ({lk_err, hit_cnt, hitm_cnt} !== 33'd0) begin failures++; $display("FAIL reset_wb status: got %b/%0d/%0d exp 0", lk_err, hit_cnt, hitm_cnt); end
    m_lk_err = 1'b0; m_hit = 0; m_hitm = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1; wb_ready = 1'b1; l1_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (snoop_valid | wb_valid | l1_valid | !bus_ready) stray++;
    end
    wb_ready = 1'b0; l1_ready = 1'b0;
    checks++; if (stray !== 0) begin failures++; $display("FAIL reset_wb dropped txn: got %0d active cycles exp 0", stray); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_read_e();
    test_rwim_m();
    test_write_self();
    test_timeout();
    test_random(30);
    test_reset_wb();
    test_random(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
